// File: rtl/pool_pkg.sv
// Shared definitions for the pooling phase sequencer: state encoding,
// phase-to-timer bit mapping and the default frame geometry.
package pool_pkg;

    // State encoding doubles as the externally visible phase code.
    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_LOAD    = 3'd1,
        PH_COMPUTE = 3'd2,
        PH_SETTLE  = 3'd3,
        PH_WRITE   = 3'd4,
        PH_FEND    = 3'd5,
        PH_ERROR   = 3'd6
    } phase_t;

    // Bit position of each phase within tmr_en / tmr_done.
    localparam int TMR_LOAD    = 0;
    localparam int TMR_COMPUTE = 1;
    localparam int TMR_SETTLE  = 2;
    localparam int TMR_WRITE   = 3;
    localparam int TMR_FEND    = 4;

    localparam int DEF_NUM_ROWS = 14;

    // One-hot timer enable for a timed phase; zero for IDLE and ERROR.
    function automatic logic [4:0] phase_tmr_en(input phase_t ph);
        logic [4:0] en;
        en = 5'b00000;
        case (ph)
            PH_LOAD:    en[TMR_LOAD]    = 1'b1;
            PH_COMPUTE: en[TMR_COMPUTE] = 1'b1;
            PH_SETTLE:  en[TMR_SETTLE]  = 1'b1;
            PH_WRITE:   en[TMR_WRITE]   = 1'b1;
            PH_FEND:    en[TMR_FEND]    = 1'b1;
            default:    en = 5'b00000;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/pool_phase_wdog.sv
// Per-phase watchdog: counts cycles spent in the current phase and flags
// the cycle in which the phase has used up its WDOG_MAX-cycle allowance.
module pool_phase_wdog #(
    parameter int WDOG_MAX = 4095,
    parameter int WDOG_W   = 12
) (
    input  logic S_AXIS_ACLK,
    input  logic S_AXIS_ARESETN,
    input  logic clr,
    output logic expire
);

    // WDOG_MAX of zero turns the watchdog off entirely.
    localparam bit                ENABLED = (WDOG_MAX != 0);
    localparam logic [WDOG_W-1:0] LIMIT   = ENABLED ? WDOG_W'(WDOG_MAX - 1) : '0;

    logic [WDOG_W-1:0] cnt;

    // Count cycles in the phase; saturate at the limit, restart on clear.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The phase's first cycle sees cnt==0, so cnt==LIMIT is its WDOG_MAX-th cycle.
    assign expire = ENABLED && (cnt == LIMIT);

endmodule

// File: rtl/pool_phase_sequencer.sv
// Frame sequencer for the pooling datapath. Walks LOAD/COMPUTE/SETTLE/WRITE
// once per output row, then FRAME_END, handshaking with the timing block
// through tmr_en/tmr_done. Stream gates open only in LOAD (input) and
// WRITE (output). Handshake: the sequencer holds tmr_en[k] high for the
// whole of phase k and leaves the phase on the edge after it samples
// tmr_done[k]=1; dropping tmr_en[k] is the timing block's cue to clear.
module pool_phase_sequencer
    import pool_pkg::*;
#(
    parameter int NUM_ROWS = DEF_NUM_ROWS,
    parameter int ROW_W    = 4,
    parameter int WDOG_MAX = 4095,
    parameter int WDOG_W   = 12
) (
    input  logic             S_AXIS_ACLK,
    input  logic             S_AXIS_ARESETN,
    input  logic             start,
    input  logic             abort,
    input  logic [4:0]       tmr_done,
    output logic [4:0]       tmr_en,
    output logic [2:0]       phase,
    output logic [ROW_W-1:0] row_idx,
    output logic             busy,
    output logic             s_tready_gate,
    output logic             m_tvalid_gate,
    output logic             frame_done,
    output logic             err
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    phase_t           state_q;
    phase_t           state_d;
    logic             wdog_clr;
    logic             wdog_expire;
    logic [4:0]       tmr_en_d;
    logic [ROW_W-1:0] row_d;
    logic             err_d;
    logic             frame_done_d;
    logic             restart;

    // Watchdog restarts on every phase change and idles outside timed phases.
    assign wdog_clr = (state_d != state_q) || (state_q == PH_IDLE) || (state_q == PH_ERROR);

    pool_phase_wdog #(
        .WDOG_MAX (WDOG_MAX),
        .WDOG_W   (WDOG_W)
    ) u_wdog (
        .S_AXIS_ACLK    (S_AXIS_ACLK),
        .S_AXIS_ARESETN (S_AXIS_ARESETN),
        .clr            (wdog_clr),
        .expire         (wdog_expire)
    );

    // State register.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q <= PH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: abort first, then the current phase's own done bit, then watchdog.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = PH_IDLE;
        end else begin
            case (state_q)
                PH_IDLE: if (start) state_d = PH_LOAD;
                PH_LOAD: begin
                    if (tmr_done[TMR_LOAD])      state_d = PH_COMPUTE;
                    else if (wdog_expire)        state_d = PH_ERROR;
                end
                PH_COMPUTE: begin
                    if (tmr_done[TMR_COMPUTE])   state_d = PH_SETTLE;
                    else if (wdog_expire)        state_d = PH_ERROR;
                end
                PH_SETTLE: begin
                    if (tmr_done[TMR_SETTLE])    state_d = PH_WRITE;
                    else if (wdog_expire)        state_d = PH_ERROR;
                end
                PH_WRITE: begin
                    if (tmr_done[TMR_WRITE])     state_d = (row_idx == LAST_ROW) ? PH_FEND : PH_LOAD;
                    else if (wdog_expire)        state_d = PH_ERROR;
                end
                PH_FEND: begin
                    if (tmr_done[TMR_FEND])      state_d = PH_IDLE;
                    else if (wdog_expire)        state_d = PH_ERROR;
                end
                PH_ERROR: if (start) state_d = PH_LOAD;
                default: state_d = PH_IDLE;
            endcase
        end
    end

    // Output decode from the next state so registered outputs line up with it.
    always_comb begin
        restart      = ((state_q == PH_IDLE) || (state_q == PH_ERROR)) && (state_d == PH_LOAD);
        tmr_en_d     = phase_tmr_en(state_d);
        row_d        = row_idx;
        err_d        = err;
        frame_done_d = (state_q == PH_FEND) && (state_d == PH_IDLE) && !abort;
        if (state_d == PH_IDLE || restart) begin
            row_d = '0;
        end else if (state_q == PH_WRITE && state_d == PH_LOAD) begin
            row_d = row_idx + 1'b1;
        end
        if (restart) begin
            err_d = 1'b0;
        end else if (state_d == PH_ERROR && state_q != PH_ERROR) begin
            err_d = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            tmr_en        <= '0;
            row_idx       <= '0;
            busy          <= 1'b0;
            s_tready_gate <= 1'b0;
            m_tvalid_gate <= 1'b0;
            frame_done    <= 1'b0;
            err           <= 1'b0;
        end else begin
            tmr_en        <= tmr_en_d;
            row_idx       <= row_d;
            busy          <= (state_d != PH_IDLE);
            s_tready_gate <= (state_d == PH_LOAD);
            m_tvalid_gate <= (state_d == PH_WRITE);
            frame_done    <= frame_done_d;
            err           <= err_d;
        end
    end

    assign phase = state_q;

endmodule

// File: tb/tb_pool_phase_sequencer.sv
// Directed bench for pool_phase_sequencer with a 3-row frame and a
// 20-cycle watchdog. A small timing-block stand-in raises done[k] five
// cycles after en[k] rises (auto mode), or the bench drives done directly.
module tb_pool_phase_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [4:0] tmr_done;
    logic [4:0] tmr_en;
    logic [2:0] phase;
    logic [1:0] row_idx;
    logic       busy;
    logic       s_tready_gate;
    logic       m_tvalid_gate;
    logic       frame_done;
    logic       err;

    logic       auto_mode;
    logic [4:0] done_man;
    logic [4:0] done_auto;
    logic [7:0] tm_cnt [5];

    int n_assert;
    int n_fail;

    logic [2:0] seq_q[$];
    logic [1:0] row_q[$];
    int         fd_cnt;
    int         busy_cyc;

    pool_phase_sequencer #(
        .NUM_ROWS (3),
        .ROW_W    (2),
        .WDOG_MAX (20),
        .WDOG_W   (12)
    ) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (rst_n),
        .start          (start),
        .abort          (abort),
        .tmr_done       (tmr_done),
        .tmr_en         (tmr_en),
        .phase          (phase),
        .row_idx        (row_idx),
        .busy           (busy),
        .s_tready_gate  (s_tready_gate),
        .m_tvalid_gate  (m_tvalid_gate),
        .frame_done     (frame_done),
        .err            (err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timing-block stand-in: count cycles while each enable is high.
    always @(posedge clk) begin
        for (int k = 0; k < 5; k++) begin
            tm_cnt[k] <= tmr_en[k] ? tm_cnt[k] + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        for (int k = 0; k < 5; k++) begin
            done_auto[k] = tmr_en[k] && (tm_cnt[k] >= 8'd5);
        end
        tmr_done = auto_mode ? done_auto : done_man;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [4:0] exp_en(input logic [2:0] ph);
        if (ph >= 3'd1 && ph <= 3'd5) return 5'(5'b00001 << (ph - 3'd1));
        return 5'b00000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_phase"}, 32'(phase), 0);
        check({tag, "_en"}, 32'(tmr_en), 0);
        check({tag, "_row"}, 32'(row_idx), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_tready"}, 32'(s_tready_gate), 0);
        check({tag, "_tvalid"}, 32'(m_tvalid_gate), 0);
        check({tag, "_fdone"}, 32'(frame_done), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    // Start a frame from IDLE and follow it back to IDLE, checking as it goes.
    task automatic run_frame(input string tag, input int exp_busy, input bit inject);
        logic [2:0] last_ph;
        seq_q.delete();
        row_q.delete();
        fd_cnt   = 0;
        busy_cyc = 0;
        last_ph  = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_lat_en"}, 32'(tmr_en), 32'h1);
        check({tag, "_lat_tready"}, 32'(s_tready_gate), 1);
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (phase != last_ph) begin
                seq_q.push_back(phase);
                if (phase == 3'd1) row_q.push_back(row_idx);
                last_ph = phase;
            end
            if (frame_done) fd_cnt++;
            if (busy) busy_cyc++;
            if (tmr_en !== exp_en(phase)) check({tag, "_en_vs_phase"}, 32'(tmr_en), 32'(exp_en(phase)));
            if (s_tready_gate !== (phase == 3'd1)) check({tag, "_tready_vs_phase"}, 32'(s_tready_gate), 32'(phase == 3'd1));
            if (m_tvalid_gate !== (phase == 3'd4)) check({tag, "_tvalid_vs_phase"}, 32'(m_tvalid_gate), 32'(phase == 3'd4));
            if (phase == 3'd0) break;
            start = (inject && phase == 3'd3 && row_idx == 2'd0);
            tick();
        end
        start = 1'b0;
        check({tag, "_ends_idle"}, 32'(phase), 0);
        check({tag, "_seq_len"}, 32'(seq_q.size()), 14);
        for (int i = 0; i < 14 && i < seq_q.size(); i++) begin
            check({tag, "_seq"}, 32'(seq_q[i]), (i < 12) ? 32'((i % 4) + 1) : ((i == 12) ? 32'd5 : 32'd0));
        end
        check({tag, "_rows_len"}, 32'(row_q.size()), 3);
        for (int i = 0; i < 3 && i < row_q.size(); i++) begin
            check({tag, "_row"}, 32'(row_q[i]), 32'(i));
        end
        check({tag, "_fdone_cnt"}, 32'(fd_cnt), 1);
        check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_busy));
    endtask

    initial begin
        int c;
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        auto_mode = 1'b1;
        done_man  = 5'b00000;

        // Reset state
        tick();
        tick();
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_all_zero("post_reset");

        // Normal 3-row frame, done arrives 5 cycles after each enable: 13 phases x 6 cycles
        run_frame("auto", 78, 1'b0);

        // Start during row-0 SETTLE is ignored: frame length unchanged
        run_frame("start_busy", 78, 1'b1);

        // Done held high: every phase lasts one cycle, 13 busy cycles
        auto_mode = 1'b0;
        done_man  = 5'b11111;
        run_frame("done_high", 13, 1'b0);

        // start and abort together in IDLE: abort wins
        done_man = 5'b00000;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_phase", 32'(phase), 0);
        check("start_abort_busy", 32'(busy), 0);

        // Stale done: done[3] high through LOAD does not move the FSM
        done_man = 5'b01000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("stale_phase", 32'(phase), 1);
        check("stale_en", 32'(tmr_en), 32'h01);
        done_man = 5'b01001;
        tick();
        check("stale_exit_phase", 32'(phase), 2);

        // Watchdog: done[1] never arrives, ERROR after 20 cycles in COMPUTE
        done_man = 5'b00000;
        c = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (phase == 3'd2) c++;
            else break;
        end
        check("wdog_cycles", 32'(c), 20);
        check("wdog_phase", 32'(phase), 6);
        check("wdog_err", 32'(err), 1);
        check("wdog_en", 32'(tmr_en), 0);
        check("wdog_tready", 32'(s_tready_gate), 0);
        check("wdog_busy", 32'(busy), 1);
        tick();
        tick();
        check("err_hold_phase", 32'(phase), 6);
        check("err_hold_err", 32'(err), 1);

        // start from ERROR restarts the frame and clears err
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err_restart_phase", 32'(phase), 1);
        check("err_restart_err", 32'(err), 0);
        check("err_restart_row", 32'(row_idx), 0);
        check("err_restart_en", 32'(tmr_en), 32'h01);

        // LOAD stalls into ERROR again, then abort leaves err set
        for (int i = 0; i < 20; i++) tick();
        check("wdog2_phase", 32'(phase), 6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("err_abort_phase", 32'(phase), 0);
        check("err_abort_err", 32'(err), 1);
        check("err_abort_busy", 32'(busy), 0);

        // Done arriving in the same cycle the watchdog expires: done wins
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        check("race_still_load", 32'(phase), 1);
        done_man = 5'b00001;
        tick();
        check("race_phase", 32'(phase), 2);
        check("race_err", 32'(err), 0);
        done_man = 5'b00000;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("race_abort_phase", 32'(phase), 0);

        // Abort during WRITE of row 1
        auto_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (!(phase == 3'd4 && row_idx == 2'd1) && c < 200) begin
            tick();
            c++;
        end
        check("abort_reach_write1", 32'(phase == 3'd4 && row_idx == 2'd1), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_phase", 32'(phase), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_en", 32'(tmr_en), 0);
        check("abort_row", 32'(row_idx), 0);
        check("abort_tvalid", 32'(m_tvalid_gate), 0);
        c = 0;
        for (int i = 0; i < 8; i++) begin
            if (frame_done) c++;
            tick();
        end
        check("abort_no_fdone", 32'(c), 0);

        // Asynchronous reset in the middle of COMPUTE
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (phase != 3'd2 && c < 50) begin
            tick();
            c++;
        end
        check("rst_reach_compute", 32'(phase), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("after_rst_phase", 32'(phase), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
